// File: rtl/field_color_vote.sv
// rtl/field_color_vote.sv - per-field colour majority vote with signal-loss detect
//
// Samples the classifier colour code once per video field, a fixed delay after
// the VREF falling edge, keeps a sliding window of the last DEPTH codes and
// publishes a colour only when one code holds at least VOTE_MIN window slots.
//
// Ports
//   llc          in   1  pixel clock, all logic on rising edge
//   rst_n        in   1  synchronous active-low reset
//   vref         in   1  decoder VREF, already in the llc domain
//   color_in     in   2  classifier code: 01 red, 10 blue, 11 green, 00 error
//   color_out    out  2  voted colour code
//   color_valid  out  1  color_out is a voted non-error colour
//   lamp         out  3  one-hot {red, green, blue}, 000 when not valid
//   sig_lost     out  1  no field seen for TIMEOUT cycles
module field_color_vote #(
    parameter int DEPTH      = 8,
    parameter int VOTE_MIN   = 6,
    parameter int SAMPLE_DLY = 2,
    parameter int TIMEOUT    = 1620000
) (
    input  logic       llc,
    input  logic       rst_n,
    input  logic       vref,
    input  logic [1:0] color_in,
    output logic [1:0] color_out,
    output logic       color_valid,
    output logic [2:0] lamp,
    output logic       sig_lost
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(SAMPLE_DLY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic                 r_vref_q;
    logic                 r_vref_d;
    logic [DW-1:0]        r_dly;
    logic                 r_decide;
    logic [2*DEPTH-1:0]   r_hist;
    logic [CW-1:0]        r_fill;
    logic [CW-1:0]        r_cnt [4];
    logic [TW-1:0]        r_timer;

    logic                 w_fall;
    logic                 w_strobe;
    logic                 w_full;
    logic [1:0]           w_evict;
    logic                 w_timeout;
    logic [CW-1:0]        w_cnt_nxt [4];
    logic [3:0]           w_hit;

    // vref is registered once before the edge detect so the fall pulse sits
    // in the cycle after the first edge that samples vref low.
    assign w_fall    = r_vref_d & ~r_vref_q;
    // Countdown value 0 means idle; the strobe is the cycle it steps 1 -> 0.
    assign w_strobe  = (r_dly == DW'(1));
    assign w_full    = (r_fill == CW'(DEPTH));
    assign w_evict   = r_hist[2*DEPTH-1 -: 2];
    // A fall in the same cycle clears the timer, so it beats the timeout.
    assign w_timeout = !w_fall && (r_timer == TW'(TIMEOUT - 1));

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
            if (color_in == 2'(k)) begin
                w_cnt_nxt[k] = w_cnt_nxt[k] + CW'(1);
            end
            if (w_full && (w_evict == 2'(k))) begin
                w_cnt_nxt[k] = w_cnt_nxt[k] - CW'(1);
            end
            w_hit[k] = (r_cnt[k] >= CW'(VOTE_MIN));
        end
    end

    always_ff @(posedge llc) begin
        if (!rst_n) begin
            r_vref_q    <= 1'b0;
            r_vref_d    <= 1'b0;
            r_dly       <= '0;
            r_decide    <= 1'b0;
            r_hist      <= '0;
            r_fill      <= '0;
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= '0;
            end
            r_timer     <= '0;
            color_out   <= 2'b00;
            color_valid <= 1'b0;
            lamp        <= 3'b000;
            sig_lost    <= 1'b0;
        end else begin
            r_vref_q <= vref;
            r_vref_d <= r_vref_q;

            if (w_fall) begin
                r_timer  <= '0;
                sig_lost <= 1'b0;
            end else if (r_timer != TW'(TIMEOUT)) begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_timeout) begin
                sig_lost    <= 1'b1;
                r_dly       <= '0;
                r_decide    <= 1'b0;
                r_hist      <= '0;
                r_fill      <= '0;
                for (int k = 0; k < 4; k++) begin
                    r_cnt[k] <= '0;
                end
                color_out   <= 2'b00;
                color_valid <= 1'b0;
                lamp        <= 3'b000;
            end else begin
                // A fall reloads even when the strobe fires this cycle; the
                // strobe below still takes its sample.
                if (w_fall) begin
                    r_dly <= DW'(SAMPLE_DLY);
                end else if (r_dly != '0) begin
                    r_dly <= r_dly - DW'(1);
                end

                r_decide <= w_strobe;

                if (w_strobe) begin
                    r_hist <= {r_hist[2*DEPTH-3:0], color_in};
                    if (!w_full) begin
                        r_fill <= r_fill + CW'(1);
                    end
                    for (int k = 0; k < 4; k++) begin
                        r_cnt[k] <= w_cnt_nxt[k];
                    end
                end

                // No branch taken means outputs hold (hysteresis).
                if (r_decide && (r_fill >= CW'(VOTE_MIN))) begin
                    if (w_hit[1]) begin
                        color_out   <= 2'b01;
                        color_valid <= 1'b1;
                        lamp        <= 3'b100;
                    end else if (w_hit[3]) begin
                        color_out   <= 2'b11;
                        color_valid <= 1'b1;
                        lamp        <= 3'b010;
                    end else if (w_hit[2]) begin
                        color_out   <= 2'b10;
                        color_valid <= 1'b1;
                        lamp        <= 3'b001;
                    end else if (w_hit[0]) begin
                        color_out   <= 2'b00;
                        color_valid <= 1'b0;
                        lamp        <= 3'b000;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_field_color_vote.sv
// tb/tb_field_color_vote.sv - bench for field_color_vote
module tb_field_color_vote;

    localparam int DEPTH    = 8;
    localparam int VOTE_MIN = 6;
    localparam int SD       = 2;
    localparam int TO       = 200;

    logic       llc = 1'b0;
    logic       rst_n = 1'b0;
    logic       vref = 1'b0;
    logic [1:0] color_in = 2'b00;
    logic [1:0] color_out;
    logic       color_valid;
    logic [2:0] lamp;
    logic       sig_lost;

    field_color_vote #(
        .DEPTH(DEPTH), .VOTE_MIN(VOTE_MIN), .SAMPLE_DLY(SD), .TIMEOUT(TO)
    ) dut (
        .llc(llc), .rst_n(rst_n), .vref(vref), .color_in(color_in),
        .color_out(color_out), .color_valid(color_valid),
        .lamp(lamp), .sig_lost(sig_lost)
    );

    always #5 llc = ~llc;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Reference model, advanced once per rising edge; n is the edge number.
    int         n = 0;
    logic       m_vprev = 1'b0;
    int         m_pfall = -1;
    int         m_pstrobe = -1;
    int         m_pdecide = -1;
    int         m_timer = 0;
    logic [1:0] m_q [$];
    logic [1:0] m_color = 2'b00;
    logic       m_valid = 1'b0;
    logic       m_lost = 1'b0;

    function automatic logic [2:0] lamp_of(input logic v, input logic [1:0] c);
        if (!v) return 3'b000;
        case (c)
            2'b01:   return 3'b100;
            2'b11:   return 3'b010;
            2'b10:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", nm, n, act, exp);
        end
    endtask

    task automatic model_step();
        logic fall_now, strobe_now, decide_now, timeout;
        int cnt [4];
        n++;
        if (!rst_n) begin
            m_vprev = 1'b0; m_pfall = -1; m_pstrobe = -1; m_pdecide = -1;
            m_timer = 0; m_q.delete(); m_color = 2'b00; m_valid = 1'b0; m_lost = 1'b0;
            return;
        end
        fall_now   = (m_pfall == n);
        strobe_now = (m_pstrobe == n);
        decide_now = (m_pdecide == n);
        timeout    = 1'b0;
        if (fall_now) begin
            m_timer = 0;
            m_lost  = 1'b0;
        end else if (m_timer < TO) begin
            m_timer++;
            if (m_timer == TO) timeout = 1'b1;
        end
        if (timeout) begin
            m_lost = 1'b1; m_q.delete(); m_color = 2'b00; m_valid = 1'b0;
            m_pstrobe = -1; m_pdecide = -1;
        end else begin
            if (decide_now && m_q.size() >= VOTE_MIN) begin
                for (int k = 0; k < 4; k++) cnt[k] = 0;
                foreach (m_q[i]) cnt[m_q[i]]++;
                if (cnt[1] >= VOTE_MIN)      begin m_color = 2'b01; m_valid = 1'b1; end
                else if (cnt[3] >= VOTE_MIN) begin m_color = 2'b11; m_valid = 1'b1; end
                else if (cnt[2] >= VOTE_MIN) begin m_color = 2'b10; m_valid = 1'b1; end
                else if (cnt[0] >= VOTE_MIN) begin m_color = 2'b00; m_valid = 1'b0; end
            end
            if (strobe_now) begin
                m_q.push_front(color_in);
                if (m_q.size() > DEPTH) void'(m_q.pop_back());
                m_pdecide = n + 1;
            end
            if (fall_now) m_pstrobe = n + SD;
        end
        if (!vref && m_vprev) m_pfall = n + 1;
        m_vprev = vref;
    endtask

    always @(posedge llc) model_step();

    always @(negedge llc) begin
        if (chk_en) begin
            check("color_out", 32'(color_out), 32'(m_color));
            check("color_valid", 32'(color_valid), 32'(m_valid));
            check("lamp", 32'(lamp), 32'(lamp_of(m_valid, m_color)));
            check("sig_lost", 32'(sig_lost), 32'(m_lost));
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge llc);
        #1;
    endtask

    task automatic field(input logic [1:0] c, input int hi, input int lo);
        vref = 1'b1;
        tick(hi);
        vref = 1'b0;
        color_in = c;
        tick(lo);
    endtask

    task automatic lit(input string nm, input logic [1:0] c, input logic v,
                       input logic [2:0] l, input logic s);
        @(negedge llc);
        check({nm, ".color"}, 32'(color_out), 32'(c));
        check({nm, ".valid"}, 32'(color_valid), 32'(v));
        check({nm, ".lamp"}, 32'(lamp), 32'(l));
        check({nm, ".lost"}, 32'(sig_lost), 32'(s));
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] dom;
        int r;
        @(posedge llc);
        #1;
        chk_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        lit("reset", 2'b00, 1'b0, 3'b000, 1'b0);

        for (int i = 0; i < 5; i++) field(2'b01, 4, 10);
        lit("red5", 2'b00, 1'b0, 3'b000, 1'b0);
        field(2'b01, 4, 10);
        lit("red6", 2'b01, 1'b1, 3'b100, 1'b0);
        for (int i = 0; i < 2; i++) field(2'b01, 4, 10);
        for (int i = 0; i < 3; i++) field(2'b11, 4, 10);
        lit("hyst", 2'b01, 1'b1, 3'b100, 1'b0);
        for (int i = 0; i < 3; i++) field(2'b11, 4, 10);
        lit("green6", 2'b11, 1'b1, 3'b010, 1'b0);

        tick(TO + 5);
        lit("timeout", 2'b00, 1'b0, 3'b000, 1'b1);
        field(2'b10, 4, 10);
        lit("relock", 2'b00, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) field(2'b10, 4, 10);
        lit("blue5", 2'b00, 1'b0, 3'b000, 1'b0);
        field(2'b10, 4, 10);
        lit("blue6", 2'b10, 1'b1, 3'b001, 1'b0);

        do_reset();
        for (int i = 0; i < 8; i++) field((i % 2 == 0) ? 2'b10 : 2'b00, 4, 10);
        lit("alt", 2'b00, 1'b0, 3'b000, 1'b0);

        // Second fall lands on the first strobe: both samples are taken.
        do_reset();
        for (int i = 0; i < 4; i++) field(2'b11, 4, 10);
        vref = 1'b1; tick(3);
        vref = 1'b0; color_in = 2'b11; tick(1);
        vref = 1'b1; tick(1);
        vref = 1'b0; tick(12);
        lit("dblfall", 2'b11, 1'b1, 3'b010, 1'b0);

        do_reset();
        for (int i = 0; i < 6; i++) field(2'b01, 4, 10);
        vref = 1'b1; tick(3);
        vref = 1'b0; color_in = 2'b01; tick(2);
        rst_n = 1'b0; tick(1);
        lit("midrst", 2'b00, 1'b0, 3'b000, 1'b0);
        rst_n = 1'b1;
        tick(10);
        for (int i = 0; i < 5; i++) field(2'b01, 4, 10);
        lit("nostrobe", 2'b00, 1'b0, 3'b000, 1'b0);

        dom = 2'b01;
        for (int it = 0; it < 700; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset();
            end else if (r < 6) begin
                vref = 1'b0;
                tick($urandom_range(TO - 20, TO + 20));
            end else begin
                if ($urandom_range(0, 19) == 0) dom = 2'($urandom_range(0, 3));
                field(($urandom_range(0, 3) < 3) ? dom : 2'($urandom_range(0, 3)),
                      $urandom_range(1, 6), $urandom_range(1, 12));
            end
        end
        tick(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
